// File: rtl/riscv_pkg.sv
// Shared fetch-stage constants, the fetch FSM encoding and the end-of-memory range check.
package riscv_pkg;

  localparam logic [31:0] INS_NOP = 32'h0000_0013;
  localparam logic [31:0] PC_STEP = 32'd4;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_END  = 2'd2
  } fetch_state_e;

  // 33-bit so a pc near 2^32 cannot wrap back into range.
  function automatic logic past_end(input logic [31:0] pc, input logic [32:0] limit);
    return ({1'b0, pc} + {1'b0, PC_STEP}) > limit;
  endfunction

endpackage

// File: rtl/ifetch_pc_gen.sv
// Next-pc select (hold / +4 / redirect) and range checks for the fetch stage.
// IFETCH_MISALIGN_CHECK_EN: misaligned redirect targets are flagged instead of truncated.
module ifetch_pc_gen
  import riscv_pkg::*;
#(
  parameter int unsigned IMEM_BYTES = 80
) (
  input  logic [31:0] pc_i,
  input  logic        load_i,
  input  logic        redirect_valid_i,
  input  logic [31:0] redirect_target_i,
  output logic [31:0] pc_d_o,
  output logic [31:0] pc_plus4_o,
  output logic        pc_past_end_o,
  output logic        tgt_past_end_o
`ifdef IFETCH_MISALIGN_CHECK_EN
  ,
  output logic        misalign_o
`endif
);

  localparam logic [32:0] LIMIT = 33'(IMEM_BYTES);

  logic [31:0] tgt;

  assign pc_plus4_o    = pc_i + PC_STEP;
  assign pc_past_end_o = past_end(pc_i, LIMIT);

`ifdef IFETCH_MISALIGN_CHECK_EN
  assign tgt        = redirect_target_i;
  assign misalign_o = redirect_target_i[1:0] != 2'b00;
`else
  logic unused_tgt_lo;
  assign tgt           = {redirect_target_i[31:2], 2'b00};
  assign unused_tgt_lo = ^redirect_target_i[1:0];
`endif

  assign tgt_past_end_o = past_end(tgt, LIMIT);

  always_comb begin
    pc_d_o = pc_i;
    if (redirect_valid_i) begin
`ifdef IFETCH_MISALIGN_CHECK_EN
      if (!misalign_o) pc_d_o = tgt;
`else
      pc_d_o = tgt;
`endif
    end else if (load_i) begin
      pc_d_o = pc_plus4_o;
    end
  end

endmodule

// File: rtl/ifetch_unit.sv
// Instruction-fetch stage: PC, fetch FSM and the IF/ID register with valid/ready to decode.
// IFETCH_MISALIGN_CHECK_EN adds a sticky misalign_err output for misaligned redirects.
module ifetch_unit
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0,
  parameter int unsigned IMEM_BYTES = 80
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_ins,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  input  logic        id_ready,
  output logic        if_valid,
  output logic [31:0] if_ins,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc_plus4,
  output logic        fetch_done
`ifdef IFETCH_MISALIGN_CHECK_EN
  ,
  output logic        misalign_err
`endif
);

  fetch_state_e state_q;
  logic [31:0]  pc_q, pc_d, pc_plus4;
  logic         vld_q;
  logic [31:0]  ins_q, ifpc_q, ifpc4_q;
  logic         pc_past_end, tgt_past_end, load;

  // Stall only blocks a load while a held word is still waiting for decode.
  assign load = (state_q == ST_RUN) && !pc_past_end && (!vld_q || id_ready);

`ifdef IFETCH_MISALIGN_CHECK_EN
  logic misalign, misalign_q;
  assign misalign_err = misalign_q;
`endif

  ifetch_pc_gen #(.IMEM_BYTES(IMEM_BYTES)) u_pc_gen (
    .pc_i              (pc_q),
    .load_i            (load),
    .redirect_valid_i  (redirect_valid),
    .redirect_target_i (redirect_target),
    .pc_d_o            (pc_d),
    .pc_plus4_o        (pc_plus4),
    .pc_past_end_o     (pc_past_end),
    .tgt_past_end_o    (tgt_past_end)
`ifdef IFETCH_MISALIGN_CHECK_EN
    ,
    .misalign_o        (misalign)
`endif
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_BOOT;
      pc_q    <= RESET_PC;
      vld_q   <= 1'b0;
      ins_q   <= INS_NOP;
      ifpc_q  <= 32'h0;
      ifpc4_q <= 32'h0;
`ifdef IFETCH_MISALIGN_CHECK_EN
      misalign_q <= 1'b0;
`endif
    end else begin
      pc_q <= pc_d;
      if (redirect_valid) begin
        // Squash whatever sits in IF/ID; the new path starts one bubble later.
        vld_q <= 1'b0;
`ifdef IFETCH_MISALIGN_CHECK_EN
        if (misalign) begin
          state_q    <= ST_END;
          misalign_q <= 1'b1;
        end else
`endif
        state_q <= tgt_past_end ? ST_END : ST_RUN;
      end else begin
        if (state_q == ST_BOOT) state_q <= ST_RUN;
        else if (state_q == ST_RUN && pc_past_end) state_q <= ST_END;
        if (load) begin
          vld_q   <= 1'b1;
          ins_q   <= imem_ins;
          ifpc_q  <= pc_q;
          ifpc4_q <= pc_plus4;
        end else if (id_ready) begin
          vld_q <= 1'b0;
        end
      end
    end
  end

  assign imem_addr   = pc_q;
  assign if_valid    = vld_q;
  assign if_ins      = ins_q;
  assign if_pc       = ifpc_q;
  assign if_pc_plus4 = ifpc4_q;
  assign fetch_done  = (state_q == ST_END);

endmodule

// File: tb/tb_ifetch_unit.sv
// Cycle table for ifetch_unit (IMEM_BYTES=20) plus a transfer scoreboard and an async-reset sequence.
module tb_ifetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] I0  = 32'h0050_0093;
  localparam logic [31:0] I1  = 32'h0090_0113;
  localparam logic [31:0] I2  = 32'h0080_026f;
  localparam logic [31:0] I3  = 32'h0020_81b3;
  localparam logic [31:0] I4  = 32'h0011_2023;
  localparam logic [31:0] TOP = 32'hffff_fffc;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] imem_addr, imem_ins, redirect_target;
  logic        redirect_valid, id_ready;
  logic        if_valid, fetch_done;
  logic [31:0] if_ins, if_pc, if_pc_plus4;
`ifdef IFETCH_MISALIGN_CHECK_EN
  logic        misalign_err;
`endif

  always #5 clk = ~clk;

  logic [31:0] prog [0:4];
  always_comb begin
    imem_ins = 32'hdead_beef;
    if (imem_addr < 32'd20) imem_ins = prog[imem_addr[4:2]];
  end

  ifetch_unit #(.RESET_PC(32'h0), .IMEM_BYTES(20)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .imem_addr       (imem_addr),
    .imem_ins        (imem_ins),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .id_ready        (id_ready),
    .if_valid        (if_valid),
    .if_ins          (if_ins),
    .if_pc           (if_pc),
    .if_pc_plus4     (if_pc_plus4),
    .fetch_done      (fetch_done)
`ifdef IFETCH_MISALIGN_CHECK_EN
    ,
    .misalign_err    (misalign_err)
`endif
  );

  typedef struct {
    logic [31:0] pc, ins, pc4;
  } xfer_t;

  typedef struct {
    logic        rdy, rv;
    logic [31:0] tgt;
    logic        vld;
    logic [31:0] pc, ins, pc4, addr;
    logic        done;
  } vec_t;

  xfer_t sb[$];
  vec_t  tbl [24];
  int    checks = 0;
  int    failures = 0;

  function automatic vec_t V(input logic rdy, input logic rv, input logic [31:0] tgt,
                             input logic vld, input logic [31:0] pc, input logic [31:0] ins,
                             input logic [31:0] pc4, input logic [31:0] addr, input logic done);
    vec_t r;
    r.rdy = rdy; r.rv = rv; r.tgt = tgt; r.vld = vld; r.pc = pc;
    r.ins = ins; r.pc4 = pc4; r.addr = addr; r.done = done;
    return r;
  endfunction

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  // A word moves to decode when valid and ready are both high before the edge.
  task automatic xfer_check();
    xfer_t e;
    if (if_valid && id_ready) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL xfer_unexpected got pc=%h ins=%h want none", if_pc, if_ins);
      end else begin
        e = sb.pop_front();
        if ({if_pc, if_ins, if_pc_plus4} !== {e.pc, e.ins, e.pc4}) begin
          failures++;
          $display("FAIL xfer got pc=%h ins=%h pc4=%h want pc=%h ins=%h pc4=%h",
                   if_pc, if_ins, if_pc_plus4, e.pc, e.ins, e.pc4);
        end
      end
    end
  endtask

  task automatic drive(input logic rdy, input logic rv, input logic [31:0] tgt);
    id_ready = rdy; redirect_valid = rv; redirect_target = tgt;
    #1;
    xfer_check();
    @(negedge clk);
  endtask

  initial begin
    prog[0] = I0; prog[1] = I1; prog[2] = I2; prog[3] = I3; prog[4] = I4;
    //            rdy rv tgt    vld pc  ins pc4 addr done
    tbl[0]  = V(1, 0, 0,     0, 0,  NOP, 0,  0,  0);
    tbl[1]  = V(1, 0, 0,     1, 0,  I0,  4,  4,  0);
    tbl[2]  = V(0, 0, 0,     1, 4,  I1,  8,  8,  0);
    tbl[3]  = V(0, 0, 0,     1, 4,  I1,  8,  8,  0);
    tbl[4]  = V(0, 0, 0,     1, 4,  I1,  8,  8,  0);
    tbl[5]  = V(1, 0, 0,     1, 4,  I1,  8,  8,  0);
    tbl[6]  = V(1, 1, 16,    1, 8,  I2,  12, 12, 0);
    tbl[7]  = V(1, 0, 0,     0, 8,  I2,  12, 16, 0);
    tbl[8]  = V(1, 0, 0,     1, 16, I4,  20, 20, 0);
    tbl[9]  = V(1, 0, 0,     0, 16, I4,  20, 20, 1);
    tbl[10] = V(1, 1, 20,    0, 16, I4,  20, 20, 1);
    tbl[11] = V(0, 1, 0,     0, 16, I4,  20, 20, 1);
    tbl[12] = V(0, 0, 0,     0, 16, I4,  20, 0,  0);
    tbl[13] = V(0, 1, 12,    1, 0,  I0,  4,  4,  0);
    tbl[14] = V(1, 0, 0,     0, 0,  I0,  4,  12, 0);
    tbl[15] = V(1, 0, 0,     1, 12, I3,  16, 16, 0);
    tbl[16] = V(0, 0, 0,     1, 16, I4,  20, 20, 0);
    tbl[17] = V(1, 0, 0,     1, 16, I4,  20, 20, 1);
    tbl[18] = V(1, 1, 18,    0, 16, I4,  20, 20, 1);
`ifdef IFETCH_MISALIGN_CHECK_EN
    tbl[19] = V(1, 0, 0,     0, 16, I4,  20, 20, 1);
    tbl[20] = V(1, 0, 0,     0, 16, I4,  20, 20, 1);
`else
    tbl[19] = V(1, 0, 0,     0, 16, I4,  20, 16, 0);
    tbl[20] = V(1, 0, 0,     1, 16, I4,  20, 20, 0);
`endif
    tbl[21] = V(1, 1, TOP,   0, 16, I4,  20, 20, 1);
    tbl[22] = V(1, 0, 0,     0, 16, I4,  20, TOP, 1);
    tbl[23] = V(0, 0, 0,     0, 16, I4,  20, TOP, 1);

    rst_n = 1'b0; id_ready = 1'b0; redirect_valid = 1'b0; redirect_target = 32'h0;
    repeat (2) @(negedge clk);
    chk("reset", {if_valid, if_pc, if_ins, if_pc_plus4, imem_addr, fetch_done},
        {1'b0, 32'h0, NOP, 32'h0, 32'h0, 1'b0});
`ifdef IFETCH_MISALIGN_CHECK_EN
    chk("reset_misalign", 160'(misalign_err), 160'(1'b0));
`endif
    rst_n = 1'b1;
    id_ready = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 24; i++) begin
      chk($sformatf("row%0d", i), {if_valid, if_pc, if_ins, if_pc_plus4, imem_addr, fetch_done},
          {tbl[i].vld, tbl[i].pc, tbl[i].ins, tbl[i].pc4, tbl[i].addr, tbl[i].done});
`ifdef IFETCH_MISALIGN_CHECK_EN
      chk($sformatf("row%0d_misalign", i), 160'(misalign_err), 160'(i >= 19));
`endif
      if (tbl[i].vld && tbl[i].rdy) sb.push_back('{tbl[i].pc, tbl[i].ins, tbl[i].pc4});
      drive(tbl[i].rdy, tbl[i].rv, tbl[i].tgt);
    end

    // Async reset while a word is stalled: the held word must never reach decode.
    drive(0, 1, 32'h0);
    drive(0, 0, 32'h0);
    chk("stall_pre_rst", {if_valid, if_pc, if_ins}, {1'b1, 32'h0, I0});
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst", {if_valid, if_pc, if_ins, if_pc_plus4, imem_addr, fetch_done},
        {1'b0, 32'h0, NOP, 32'h0, 32'h0, 1'b0});
`ifdef IFETCH_MISALIGN_CHECK_EN
    chk("async_rst_misalign", 160'(misalign_err), 160'(1'b0));
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("boot_no_fetch", {if_valid, imem_addr}, {1'b0, 32'h0});
    drive(1, 0, 32'h0);
    chk("refetch", {if_valid, if_pc, if_ins, imem_addr}, {1'b1, 32'h0, I0, 32'h4});
    sb.push_back('{32'h0, I0, 32'h4});
    drive(1, 0, 32'h0);
    chk("refetch_next", {if_valid, if_pc, if_ins}, {1'b1, 32'h4, I1});
    drive(0, 0, 32'h0);
    chk("sb_empty", 160'(sb.size()), 160'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
